// File: rtl/mem_pkg.sv
// Shared definitions for the data memory controller: size codes, FSM states
// and byte-lane width helpers.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam int BYTE_W = 8;

  // Number of address bits that select a byte lane inside one memory word.
  function automatic int lane_bits(input int data_w);
    return $clog2(data_w / BYTE_W);
  endfunction

  // Width of a bit-shift amount derived from a lane offset.
  function automatic int off_shift_w(input int data_w);
    return lane_bits(data_w) + 3;
  endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between a requester (master) and the data memory controller (slave).
interface data_memory_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_error;
  logic              init_done;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error, init_done
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error, init_done
  );
endinterface

// File: rtl/mem_align.sv
// Byte-lane alignment: merges store data into an existing word and extracts,
// shifts and extends load data.
module mem_align
  import mem_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int L      = lane_bits(DATA_W),
  localparam int SH_W   = off_shift_w(DATA_W)
) (
  input  size_e             size,
  input  logic              sgn,
  input  logic [L-1:0]      offset,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] rd_word,
  output logic [DATA_W-1:0] st_word,
  output logic [DATA_W-1:0] ld_data
);

  logic [DATA_W-1:0] fmask;
  logic [DATA_W-1:0] raw;
  logic [SH_W-1:0]   sh;
  logic              sbit;

  always_comb begin
    sh    = {offset, 3'b000};
    fmask = '1;
    case (size)
      SZ_BYTE: fmask = DATA_W'(64'h0000_0000_0000_00FF);
      SZ_HALF: fmask = DATA_W'(64'h0000_0000_0000_FFFF);
      SZ_WORD: fmask = DATA_W'(64'h0000_0000_FFFF_FFFF);
      default: fmask = '1;
    endcase
    raw = (rd_word >> sh) & fmask;
    case (size)
      SZ_BYTE: sbit = raw[7];
      SZ_HALF: sbit = raw[15];
      SZ_WORD: sbit = raw[31];
      default: sbit = 1'b0;
    endcase
    // Sign extension fills every bit above the selected field.
    ld_data = raw | ((sgn && sbit) ? ~fmask : '0);
    st_word = (old_word & ~(fmask << sh)) | ((wdata & fmask) << sh);
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Single-outstanding data memory controller with a post-reset clear sweep,
// programmable access latency and byte/half/word/dword loads and stores.
module data_memory_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 1
) (
  input logic               clk,
  input logic               rst,
  data_memory_ctrl_if.slave bus
);

  localparam int L     = lane_bits(DATA_W);
  localparam int IDX_W = $clog2(DEPTH);

  state_e             state;
  logic [IDX_W-1:0]   clr_idx;
  logic [1:0]         cnt;

  logic               wr_q;
  logic               sgn_q;
  size_e              size_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rd_word_p0;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic [IDX_W-1:0]   idx;
  logic [L-1:0]       off;
  logic               err;
  logic               access;
  logic               mem_we;
  logic [IDX_W-1:0]   mem_widx;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  st_word;
  logic [DATA_W-1:0]  ld_data;

  assign idx    = addr_q[L+IDX_W-1:L];
  assign off    = addr_q[L-1:0];
  assign access = (state == ST_WAIT) && (cnt == 2'd0);

  always_comb begin
    err = (addr_q >> (L + IDX_W)) != '0;
    case (size_q)
      SZ_HALF:  err = err | addr_q[0];
      SZ_WORD:  err = err | (|addr_q[1:0]);
      SZ_DWORD: err = err | (DATA_W == 32) | (|addr_q[2:0]);
      default:  err = err;
    endcase
  end

  // The sweep owns the write port while clearing; rejected stores never write.
  assign mem_we    = (state == ST_CLEAR) || (access && wr_q && !err);
  assign mem_widx  = (state == ST_CLEAR) ? clr_idx : idx;
  assign mem_wdata = (state == ST_CLEAR) ? '0 : st_word;

  mem_align #(.DATA_W(DATA_W)) u_align (
    .size     (size_q),
    .sgn      (sgn_q),
    .offset   (off),
    .wdata    (wdata_q),
    .old_word (mem[idx]),
    .rd_word  (rd_word_p0),
    .st_word  (st_word),
    .ld_data  (ld_data)
  );

  // Stage p0: request capture, memory write and read-word register
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
    if (access) rd_word_p0 <= mem[idx];
    if (state == ST_IDLE && bus.req_valid) begin
      wr_q    <= bus.req_write;
      sgn_q   <= bus.req_signed;
      size_q  <= size_e'(bus.req_size);
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_CLEAR;
      clr_idx        <= '0;
      cnt            <= '0;
      bus.req_ready  <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_error <= 1'b0;
      bus.init_done  <= 1'b0;
    end else begin
      bus.resp_valid <= 1'b0;
      case (state)
        ST_CLEAR: begin
          if (clr_idx == IDX_W'(DEPTH - 1)) begin
            state         <= ST_IDLE;
            bus.init_done <= 1'b1;
            bus.req_ready <= 1'b1;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        ST_IDLE: begin
          if (bus.req_valid) begin
            state         <= ST_WAIT;
            cnt           <= 2'(LATENCY - 1);
            bus.req_ready <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (cnt == 2'd0) state <= ST_RESP;
          else             cnt   <= cnt - 1'b1;
        end
        ST_RESP: begin
          bus.resp_valid <= 1'b1;
          bus.resp_error <= err;
          bus.resp_rdata <= (!wr_q && !err) ? ld_data : '0;
          bus.req_ready  <= 1'b1;
          state          <= ST_IDLE;
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench: three controller instances (32-bit/lat 1, 32-bit/lat 3, 64-bit/lat 1).
module tb_data_memory_ctrl;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  data_memory_ctrl_if #(.DATA_W(32), .ADDR_W(32)) ifa ();
  data_memory_ctrl_if #(.DATA_W(32), .ADDR_W(32)) ifb ();
  data_memory_ctrl_if #(.DATA_W(64), .ADDR_W(32)) ifc ();

  data_memory_ctrl #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .LATENCY(1))
    u_a (.clk(clk), .rst(rst), .bus(ifa));
  data_memory_ctrl #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .LATENCY(3))
    u_b (.clk(clk), .rst(rst_b), .bus(ifb));
  data_memory_ctrl #(.DATA_W(64), .DEPTH(256), .ADDR_W(32), .LATENCY(1))
    u_c (.clk(clk), .rst(rst), .bus(ifc));

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic drive(input int s, input logic v, input logic w, input logic [1:0] sz,
                       input logic sg, input logic [31:0] ad, input logic [63:0] wd);
    case (s)
      0: begin
        ifa.req_valid = v; ifa.req_write = w; ifa.req_size = sz;
        ifa.req_signed = sg; ifa.req_addr = ad; ifa.req_wdata = wd[31:0];
      end
      1: begin
        ifb.req_valid = v; ifb.req_write = w; ifb.req_size = sz;
        ifb.req_signed = sg; ifb.req_addr = ad; ifb.req_wdata = wd[31:0];
      end
      default: begin
        ifc.req_valid = v; ifc.req_write = w; ifc.req_size = sz;
        ifc.req_signed = sg; ifc.req_addr = ad; ifc.req_wdata = wd;
      end
    endcase
  endtask

  function automatic logic rdy(input int s);
    case (s)
      0:       return ifa.req_ready;
      1:       return ifb.req_ready;
      default: return ifc.req_ready;
    endcase
  endfunction

  function automatic logic rvld(input int s);
    case (s)
      0:       return ifa.resp_valid;
      1:       return ifb.resp_valid;
      default: return ifc.resp_valid;
    endcase
  endfunction

  function automatic logic idone(input int s);
    case (s)
      0:       return ifa.init_done;
      1:       return ifb.init_done;
      default: return ifc.init_done;
    endcase
  endfunction

  // Issue one request, queue its expected response and check response latency.
  task automatic issue(input int s, input string nm, input logic w, input logic [1:0] sz,
                       input logic sg, input logic [31:0] ad, input logic [63:0] wd,
                       input logic [63:0] ex, input logic er);
    exp_t e;
    int   n;
    int   k;
    int   lat;
    lat = (s == 1) ? 3 : 1;
    @(negedge clk);
    drive(s, 1'b1, w, sz, sg, ad, wd);
    n = 0;
    while (!rdy(s) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!rdy(s)) begin
      checks++; errors++;
      $display("FAIL %s accept: req_ready=0 want 1", nm);
      drive(s, 1'b0, w, sz, sg, ad, wd);
      return;
    end
    e.rdata = ex; e.err = er; e.name = nm;
    case (s)
      0:       qa.push_back(e);
      1:       qb.push_back(e);
      default: qc.push_back(e);
    endcase
    @(posedge clk); #1;
    drive(s, 1'b0, w, sz, sg, ad, wd);
    k = 0;
    while (!rvld(s) && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (k != lat + 1) begin
      errors++;
      $display("FAIL %s latency: got %0d edges want %0d", nm, k, lat + 1);
    end
  endtask

  task automatic wait_init(input int s, input string nm);
    int k;
    k = 0;
    while (!idone(s) && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (k != 256) begin
      errors++;
      $display("FAIL %s init_done edges: got %0d want 256", nm, k);
    end
  endtask

  always @(negedge clk) begin
    if (ifa.resp_valid) begin
      exp_t e;
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_resp: rdata=%h err=%b want no response", ifa.resp_rdata, ifa.resp_error);
      end else begin
        e = qa.pop_front();
        if (ifa.resp_rdata !== e.rdata[31:0] || ifa.resp_error !== e.err) begin
          errors++;
          $display("FAIL %s: rdata=%h err=%b want rdata=%h err=%b",
                   e.name, ifa.resp_rdata, ifa.resp_error, e.rdata[31:0], e.err);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (ifb.resp_valid) begin
      exp_t e;
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_resp: rdata=%h err=%b want no response", ifb.resp_rdata, ifb.resp_error);
      end else begin
        e = qb.pop_front();
        if (ifb.resp_rdata !== e.rdata[31:0] || ifb.resp_error !== e.err) begin
          errors++;
          $display("FAIL %s: rdata=%h err=%b want rdata=%h err=%b",
                   e.name, ifb.resp_rdata, ifb.resp_error, e.rdata[31:0], e.err);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (ifc.resp_valid) begin
      exp_t e;
      checks++;
      if (qc.size() == 0) begin
        errors++;
        $display("FAIL c_unexpected_resp: rdata=%h err=%b want no response", ifc.resp_rdata, ifc.resp_error);
      end else begin
        e = qc.pop_front();
        if (ifc.resp_rdata !== e.rdata || ifc.resp_error !== e.err) begin
          errors++;
          $display("FAIL %s: rdata=%h err=%b want rdata=%h err=%b",
                   e.name, ifc.resp_rdata, ifc.resp_error, e.rdata, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b0;
    rst_b = 1'b0;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 64'h0);
    #23;
    chk("rst_req_ready",  64'(ifa.req_ready),  64'h0);
    chk("rst_resp_valid", 64'(ifa.resp_valid), 64'h0);
    chk("rst_resp_rdata", 64'(ifa.resp_rdata), 64'h0);
    chk("rst_resp_error", 64'(ifa.resp_error), 64'h0);
    chk("rst_init_done",  64'(ifa.init_done),  64'h0);

    @(negedge clk);
    rst   = 1'b1;
    rst_b = 1'b1;
    wait_init(0, "a_init");
    chk("a_ready_after_init", 64'(ifa.req_ready), 64'h1);
    chk("b_init_done", 64'(ifb.init_done), 64'h1);
    chk("c_init_done", 64'(ifc.init_done), 64'h1);

    // 32-bit, latency 1
    issue(0, "a_ld_w_0",       1'b0, SZ_WORD, 1'b0, 32'h0,   64'h0,        64'h0,        1'b0);
    issue(0, "a_st_w_10",      1'b1, SZ_WORD, 1'b0, 32'h10,  64'h8899AABB, 64'h0,        1'b0);
    issue(0, "a_ld_b_13_s",    1'b0, SZ_BYTE, 1'b1, 32'h13,  64'h0,        64'hFFFFFF88, 1'b0);
    issue(0, "a_ld_b_13_u",    1'b0, SZ_BYTE, 1'b0, 32'h13,  64'h0,        64'h00000088, 1'b0);
    issue(0, "a_st_h_12",      1'b1, SZ_HALF, 1'b0, 32'h12,  64'h1234,     64'h0,        1'b0);
    issue(0, "a_ld_w_10",      1'b0, SZ_WORD, 1'b0, 32'h10,  64'h0,        64'h1234AABB, 1'b0);
    issue(0, "a_ld_h_10_s",    1'b0, SZ_HALF, 1'b1, 32'h10,  64'h0,        64'hFFFFAABB, 1'b0);
    issue(0, "a_ld_h_12_s",    1'b0, SZ_HALF, 1'b1, 32'h12,  64'h0,        64'h00001234, 1'b0);
    issue(0, "a_ld_w_11_err",  1'b0, SZ_WORD, 1'b0, 32'h11,  64'h0,        64'h0,        1'b1);
    issue(0, "a_st_w_400_err", 1'b1, SZ_WORD, 1'b0, 32'h400, 64'hDEADBEEF, 64'h0,        1'b1);
    issue(0, "a_ld_w_0_after", 1'b0, SZ_WORD, 1'b0, 32'h0,   64'h0,        64'h0,        1'b0);
    issue(0, "a_ld_h_3_err",   1'b0, SZ_HALF, 1'b0, 32'h3,   64'h0,        64'h0,        1'b1);
    issue(0, "a_ld_d_0_err",   1'b0, SZ_DWORD, 1'b0, 32'h0,  64'h0,        64'h0,        1'b1);
    issue(0, "a_st_b_1",       1'b1, SZ_BYTE, 1'b0, 32'h1,   64'hFFFFFF5A, 64'h0,        1'b0);
    issue(0, "a_ld_w_0_byte",  1'b0, SZ_WORD, 1'b0, 32'h0,   64'h0,        64'h00005A00, 1'b0);
    issue(0, "a_st_w_3fc",     1'b1, SZ_WORD, 1'b0, 32'h3FC, 64'hCAFEF00D, 64'h0,        1'b0);
    issue(0, "a_ld_w_3fc",     1'b0, SZ_WORD, 1'b0, 32'h3FC, 64'h0,        64'hCAFEF00D, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("a_hold_rdata", 64'(ifa.resp_rdata), 64'hCAFEF00D);
    chk("a_hold_valid", 64'(ifa.resp_valid), 64'h0);

    // 32-bit, latency 3, including reset in the middle of a request
    issue(1, "b_ld_w_4", 1'b0, SZ_WORD, 1'b0, 32'h4, 64'h0, 64'h0, 1'b0);
    @(negedge clk);
    drive(1, 1'b1, 1'b1, SZ_WORD, 1'b0, 32'h8, 64'h11223344);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h8, 64'h11223344);
    @(posedge clk); #1;
    rst_b = 1'b0;
    #1;
    chk("b_abort_init_done",  64'(ifb.init_done),  64'h0);
    chk("b_abort_req_ready",  64'(ifb.req_ready),  64'h0);
    chk("b_abort_resp_valid", 64'(ifb.resp_valid), 64'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    wait_init(1, "b_reinit");
    issue(1, "b_ld_w_8_after", 1'b0, SZ_WORD, 1'b0, 32'h8, 64'h0, 64'h0, 1'b0);

    // 64-bit, latency 1
    issue(2, "c_st_d_8",      1'b1, SZ_DWORD, 1'b0, 32'h8,   64'h0123456789ABCDEF, 64'h0, 1'b0);
    issue(2, "c_ld_h_e_s",    1'b0, SZ_HALF,  1'b1, 32'hE,   64'h0, 64'h0000000000000123, 1'b0);
    issue(2, "c_ld_w_c_u",    1'b0, SZ_WORD,  1'b0, 32'hC,   64'h0, 64'h0000000001234567, 1'b0);
    issue(2, "c_ld_b_8_s",    1'b0, SZ_BYTE,  1'b1, 32'h8,   64'h0, 64'hFFFFFFFFFFFFFFEF, 1'b0);
    issue(2, "c_ld_d_8",      1'b0, SZ_DWORD, 1'b0, 32'h8,   64'h0, 64'h0123456789ABCDEF, 1'b0);
    issue(2, "c_ld_w_c_s",    1'b0, SZ_WORD,  1'b1, 32'hC,   64'h0, 64'h0000000001234567, 1'b0);
    issue(2, "c_ld_w_8_s",    1'b0, SZ_WORD,  1'b1, 32'h8,   64'h0, 64'hFFFFFFFF89ABCDEF, 1'b0);
    issue(2, "c_ld_d_c_err",  1'b0, SZ_DWORD, 1'b0, 32'hC,   64'h0, 64'h0, 1'b1);
    issue(2, "c_st_d_800_err",1'b1, SZ_DWORD, 1'b0, 32'h800, 64'h55AA55AA55AA55AA, 64'h0, 1'b1);

    repeat (5) @(posedge clk);
    chk("a_queue_empty", 64'(qa.size()), 64'h0);
    chk("b_queue_empty", 64'(qb.size()), 64'h0);
    chk("c_queue_empty", 64'(qc.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 Parameters SHALL be declared as follows:
  DATA_W, 32, data width in bits; legal values 32 or 64.
  DEPTH, 256, number of words.
  ADDR_W, 32, byte-address width.
  LATENCY, 1, cycles from request accept to response; legal range 1..4.
REQ-002 Ports SHALL be declared as follows:
  clk  in  1  the only clock; all state updates on its rising edge.
  rst  in  1  asynchronous, active-low reset.
  req_valid  in  1  a request is present.
  req_ready  out  1  the controller can accept a request.
  req_write  in  1  1 = store, 0 = load.
  req_size  in  2  00 byte, 01 half, 10 word, 11 dword (legal only when DATA_W=64).
  req_signed  in  1  loads are sign-extended when 1, zero-extended when 0.
  req_addr  in  ADDR_W  byte address.
  req_wdata  in  DATA_W  store data, LSB-aligned.
  resp_valid  out  1  one-cycle response strobe.
  resp_rdata  out  DATA_W  load result; 0 for stores and for errors.
  resp_error  out  1  the request was rejected; valid only with resp_valid.
  init_done  out  1  the post-reset clear sweep has completed.

Function
REQ-003 The FSM SHALL have four states: CLEAR, IDLE, WAIT, RESP.
REQ-004 In CLEAR, the controller SHALL zero one word per cycle for word indices 0..DEPTH-1, then enter IDLE and set init_done=1; req_ready SHALL be 0 throughout.
REQ-005 In IDLE, req_ready SHALL be 1; when req_valid=1, the request SHALL be captured and the FSM SHALL move to WAIT with its counter loaded to LATENCY-1.
REQ-006 In WAIT, the counter SHALL decrement each cycle; at 0, the memory access SHALL be performed and the FSM SHALL move to RESP.
REQ-007 In RESP, resp_valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-008 resp_valid SHALL rise exactly LATENCY+1 edges after the accept edge; only one request SHALL be outstanding; no response backpressure is provided.
REQ-009 Addressing SHALL be little-endian: lane bits L = log2(DATA_W/8); word index = req_addr[L+log2(DEPTH)-1:L].
REQ-010 resp_error SHALL be set for any of: a misaligned half (addr[0]=1); a misaligned word (addr[1:0]≠0); a misaligned dword (addr[2:0]≠0); size 11 when DATA_W=32; any address bit at or above L+log2(DEPTH) being nonzero.
REQ-011 An erroring request SHALL not modify memory, and resp_rdata SHALL be 0.
REQ-012 A store SHALL update only the byte lanes selected by size and offset; all other lanes SHALL be preserved.
REQ-013 A load SHALL shift the selected bytes to the LSB, then extend them according to req_signed.
REQ-014 resp_rdata and resp_error SHALL hold their values until the next RESP.

Reset
REQ-015 Asserting rst (rst=0) SHALL immediately force the FSM to CLEAR, the sweep index to 0, req_ready=0, resp_valid=0, resp_rdata=0, resp_error=0, and init_done=0.
REQ-016 If reset is asserted mid-request (WAIT or RESP), the pending request SHALL be discarded with no response and no memory write, and the clear sweep SHALL restart.

Structure
REQ-017 A shared package mem_pkg SHALL hold the size encodings, the FSM state enum, and the LANE/offset width helper constants.
REQ-018 A combinational sub-module mem_align SHALL perform byte-lane merging for stores and shift/extension for loads.

Verification (DATA_W=32, DEPTH=256, LATENCY=1 unless stated)
REQ-019 Release reset -> init_done rises after 256 clear cycles; a word read at 0x0 returns 0x00000000 with resp_valid exactly 2 edges after accept.
REQ-020 Store word 0x10=0x8899AABB; load byte 0x13 signed -> 0xFFFFFF88; load byte 0x13 unsigned -> 0x00000088.
REQ-021 Store half 0x12=0x1234; load word 0x10 -> 0x1234AABB.
REQ-022 Load word at 0x11 -> resp_error=1, rdata=0; store word at 0x400 -> resp_error=1, and a subsequent load at 0x0 is unchanged.
REQ-023 LATENCY=3: assert rst during WAIT -> no resp_valid is produced, init_done=0, and the sweep restarts at index 0.
REQ-024 DATA_W=64: store dword 0x8=0x0123456789ABCDEF; load half 0xE signed -> 0x0000000000000123.
